// File: rtl/dso_trig_if.sv
// Acquisition-side bundle for dso_trig_capture: ADC input, trigger setup, RAM write port and capture status.
// The master modport drives samples and control; the slave modport is the capture engine.
interface dso_trig_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] adc_data;
    logic                  adc_valid;
    logic                  arm;
    logic                  abort;
    logic [DATA_WIDTH-1:0] trig_level;
    logic                  trig_edge;
    logic [ADDR_WIDTH-1:0] pretrig_depth;

    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  forced;

    modport master (
        output adc_data, adc_valid, arm, abort, trig_level, trig_edge, pretrig_depth,
        input  wr_data, wr_addr, wr_en, busy, done, trig_addr, start_addr, forced
    );

    modport slave (
        input  adc_data, adc_valid, arm, abort, trig_level, trig_edge, pretrig_depth,
        output wr_data, wr_addr, wr_en, busy, done, trig_addr, start_addr, forced
    );
endinterface

// File: rtl/dso_trig_capture.sv
// DSO trigger/capture engine: circular pre-trigger history, level/edge trigger, post-trigger fill into the sample RAM.
// Optional auto-trigger timeout is enabled by defining DSO_AUTO_TRIG_EN.
module dso_trig_capture #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter logic [15:0] AUTO_TIMEOUT = 16'd50000
) (
    input logic       wr_clk,
    input logic       wr_rst,
    dso_trig_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pretrig_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] pre_cnt_q;
    logic [ADDR_WIDTH-1:0] post_cnt_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  prev_vld_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] trig_addr_q;
    logic [ADDR_WIDTH-1:0] start_addr_q;
    logic                  forced_q;

    logic active;
    logic sample_wr;
    logic rise_hit;
    logic fall_hit;
    logic edge_hit;
    logic auto_hit;
    logic trig_fire;

    assign active    = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign sample_wr = active && bus.adc_valid;
    assign rise_hit  = (prev_q < bus.trig_level) && (bus.adc_data >= bus.trig_level);
    assign fall_hit  = (prev_q > bus.trig_level) && (bus.adc_data <= bus.trig_level);
    assign edge_hit  = prev_vld_q && (bus.trig_edge ? fall_hit : rise_hit);
    assign trig_fire = sample_wr && (state_q == S_WAIT_TRIG) && (edge_hit || auto_hit);

`ifdef DSO_AUTO_TRIG_EN
    logic [15:0] auto_cnt_q;

    // Held at zero outside WAIT_TRIG, so it always starts from zero on entry.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            auto_cnt_q <= '0;
        end else if (state_q != S_WAIT_TRIG || bus.abort) begin
            auto_cnt_q <= '0;
        end else if (sample_wr) begin
            auto_cnt_q <= auto_cnt_q + 16'd1;
        end
    end

    assign auto_hit = (auto_cnt_q + 16'd1) == AUTO_TIMEOUT;
`else
    logic unused_auto_timeout;

    assign unused_auto_timeout = ^AUTO_TIMEOUT;
    assign auto_hit            = 1'b0;
`endif

    // NOTE: every register in this block uses <= so all updates see the pre-edge values.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q      <= S_IDLE;
            pretrig_q    <= '0;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            forced_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (bus.abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                if (sample_wr) begin
                    wr_en_q    <= 1'b1;
                    wr_data_q  <= bus.adc_data;
                    wr_addr_q  <= wr_ptr_q;
                    wr_ptr_q   <= wr_ptr_q + ADDR_ONE;
                    prev_q     <= bus.adc_data;
                    prev_vld_q <= 1'b1;
                end

                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (bus.arm) begin
                            pretrig_q  <= bus.pretrig_depth;
                            wr_ptr_q   <= '0;
                            pre_cnt_q  <= '0;
                            prev_vld_q <= 1'b0;
                            done_q     <= 1'b0;
                            forced_q   <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= (bus.pretrig_depth == '0) ? S_WAIT_TRIG : S_PRE;
                        end
                    end

                    S_PRE: begin
                        if (sample_wr) begin
                            pre_cnt_q <= pre_cnt_q + ADDR_ONE;
                            if (pre_cnt_q == pretrig_q - ADDR_ONE) begin
                                state_q <= S_WAIT_TRIG;
                            end
                        end
                    end

                    S_WAIT_TRIG: begin
                        if (trig_fire) begin
                            trig_addr_q  <= wr_ptr_q;
                            start_addr_q <= wr_ptr_q - pretrig_q;
                            // ~pretrig is DEPTH-1-pretrig: the samples still owed after the trigger one.
                            post_cnt_q   <= ~pretrig_q;
                            forced_q     <= !edge_hit;
                            if (pretrig_q == '1) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end

                    S_POST: begin
                        if (sample_wr) begin
                            post_cnt_q <= post_cnt_q - ADDR_ONE;
                            if (post_cnt_q == ADDR_ONE) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.wr_data    = wr_data_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trig_addr  = trig_addr_q;
    assign bus.start_addr = start_addr_q;
    assign bus.forced     = forced_q;
endmodule

// File: tb/tb_dso_trig_capture.sv
// Randomized and directed bench for dso_trig_capture, checked every cycle against a sample-index capture model.
// Define DSO_AUTO_TRIG_EN for both the bench and the RTL to exercise the auto-trigger timeout.
module tb_dso_trig_capture;
    localparam int AW      = 10;
    localparam int DW      = 8;
    localparam int DEPTH   = 1 << AW;
    localparam int TIMEOUT = 100;
`ifdef DSO_AUTO_TRIG_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dso_trig_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dso_trig_capture #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .AUTO_TIMEOUT(16'(TIMEOUT))
    ) dut (
        .wr_clk(clk),
        .wr_rst(rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream sample RAM, filled from the write port.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;

    // Capture model in terms of sample indices since arm.
    int          ptd;
    logic        edg;
    logic [7:0]  lvl;
    bit          m_active, m_trig_seen, m_have_prev;
    int          m_pre, m_n, m_trig_n, m_wait;
    logic [7:0]  m_prev;
    bit          exp_wr_en, exp_busy, exp_done, exp_forced;
    int          exp_wr_addr, exp_trig, exp_start;
    logic [7:0]  exp_wr_data;

    task automatic model_reset();
        m_active = 0; m_trig_seen = 0; m_have_prev = 0;
        m_pre = 0; m_n = 0; m_trig_n = 0; m_wait = 0; m_prev = 8'h00;
        exp_wr_en = 0; exp_busy = 0; exp_done = 0; exp_forced = 0;
        exp_wr_addr = 0; exp_trig = 0; exp_start = 0; exp_wr_data = 8'h00;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit a, input bit ab);
        bit natural;
        bit auto_fire;
        exp_wr_en = 1'b0;
        if (ab) begin
            m_active = 0; exp_busy = 0; exp_done = 0;
        end else if (!m_active) begin
            if (a) begin
                m_active = 1; m_pre = ptd; m_n = 0; m_trig_seen = 0; m_have_prev = 0; m_wait = 0;
                exp_busy = 1; exp_done = 0; exp_forced = 0;
            end
        end else if (v) begin
            exp_wr_en   = 1;
            exp_wr_addr = m_n % DEPTH;
            exp_wr_data = d;
            m_n++;
            if (!m_trig_seen && m_n > m_pre) begin
                m_wait++;
                if (edg) natural = m_have_prev && (m_prev > lvl) && (d <= lvl);
                else     natural = m_have_prev && (m_prev < lvl) && (d >= lvl);
                auto_fire = AUTO_EN && (m_wait == TIMEOUT);
                if (natural || auto_fire) begin
                    m_trig_seen = 1;
                    m_trig_n    = m_n - 1;
                    exp_trig    = (m_n - 1) % DEPTH;
                    exp_start   = (((m_n - 1 - m_pre) % DEPTH) + DEPTH) % DEPTH;
                    exp_forced  = !natural;
                end
            end
            if (m_trig_seen && (m_n - m_trig_n) == DEPTH - m_pre) begin
                m_active = 0; exp_busy = 0; exp_done = 1;
            end
            m_prev = d;
            m_have_prev = 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_en", bus.wr_en, exp_wr_en);
            if (exp_wr_en) begin
                check("wr_addr", bus.wr_addr, exp_wr_addr);
                check("wr_data", bus.wr_data, exp_wr_data);
            end
            check("busy", bus.busy, exp_busy);
            check("done", bus.done, exp_done);
            check("trig_addr", bus.trig_addr, exp_trig);
            check("start_addr", bus.start_addr, exp_start);
            check("forced", bus.forced, exp_forced);
        end
    end

    task automatic cycle(input bit v, input logic [7:0] d, input bit a, input bit ab);
        bus.adc_valid = v;
        bus.adc_data  = d;
        bus.arm       = a;
        bus.abort     = ab;
        @(posedge clk);
        #1;
        model_step(v, d, a, ab);
    endtask

    task automatic arm_capture(input int pd, input logic e, input logic [7:0] l);
        ptd = pd; edg = e; lvl = l;
        bus.pretrig_depth = AW'(pd);
        bus.trig_edge     = e;
        bus.trig_level    = l;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // kind: 0 ramp up, 1 ramp down from 0xFF, 2 constant 0x10, 3 random with random arm/abort pulses
    task automatic run_capture(input int kind, input int budget, output bit finished);
        int i = 0;
        int cyc = 0;
        bit v;
        bit a;
        bit ab;
        logic [7:0] d;
        while (m_active && cyc < budget) begin
            a = 0; ab = 0; v = 1;
            case (kind)
                0: d = 8'(i);
                1: d = 8'(255 - (i % 256));
                2: d = 8'h10;
                default: begin
                    d  = 8'($urandom_range(0, 255));
                    v  = ($urandom_range(0, 3) != 0);
                    a  = ($urandom_range(0, 49) == 0);
                    ab = ($urandom_range(0, 2999) == 0);
                end
            endcase
            cycle(v, d, a, ab);
            if (v) i++;
            cyc++;
        end
        finished = !m_active;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit fin;
        int bad;
        int post_seen;
        int i;

        bus.adc_valid = 0; bus.adc_data = 0; bus.arm = 0; bus.abort = 0;
        bus.trig_level = 0; bus.trig_edge = 0; bus.pretrig_depth = 0;
        ptd = 0; edg = 0; lvl = 0;
        model_reset();
        chk_en = 1'b1;

        // Reset held 200 ns with no valid samples.
        #199;
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_trig_addr", bus.trig_addr, 0);
        check("rst_start_addr", bus.start_addr, 0);
        check("rst_forced", bus.forced, 0);
        #2 rst = 1'b0;
        repeat (100) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Rising trigger at 0x80 with 256 samples of history.
        arm_capture(256, 1'b0, 8'h80);
        run_capture(0, 3000, fin);
        check("ramp_up_finished", fin, 1);
        check("ramp_up_trig_addr", bus.trig_addr, 384);
        check("ramp_up_start_addr", bus.start_addr, 128);
        check("ramp_up_done", bus.done, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        bad = 0;
        for (int k = 0; k < DEPTH; k++)
            if (ram[(128 + k) % DEPTH] !== 8'((128 + k) % 256)) bad++;
        check("ram_contiguous_ramp", bad, 0);
        check("ram_at_trig", ram[384], 8'h80);

        // Falling trigger at 0x40, no history.
        arm_capture(0, 1'b1, 8'h40);
        run_capture(1, 3000, fin);
        check("ramp_down_finished", fin, 1);
        check("ramp_down_trig_addr", bus.trig_addr, 10'h0BF);
        check("ramp_down_start_addr", bus.start_addr, 10'h0BF);
        check("ramp_down_done", bus.done, 1);

        // Maximum history: completes on the trigger write itself.
        arm_capture(1023, 1'b0, 8'h80);
        run_capture(0, 3000, fin);
        check("full_pre_finished", fin, 1);
        check("full_pre_trig_addr", bus.trig_addr, 128);
        check("full_pre_start_addr", bus.start_addr, 129);
        check("full_pre_done", bus.done, 1);

        // Gapped samples, arm while busy, abort during post-trigger fill.
        arm_capture(16, 1'b0, 8'h80);
        i = 0;
        post_seen = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit v;
            v = (cyc % 2 == 0);
            if (m_trig_seen && post_seen >= 10) break;
            cycle(v, 8'(i), (cyc == 5), 1'b0);
            if (v) begin
                i++;
                if (m_trig_seen) post_seen++;
            end
        end
        check("gap_reached_post", post_seen, 10);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_trig_held", bus.trig_addr, 128);
        check("abort_start_held", bus.start_addr, 112);
        cycle(1'b1, 8'h55, 1'b1, 1'b1);
        check("abort_beats_arm", bus.busy, 0);
        cycle(1'b1, 8'h56, 1'b0, 1'b0);
        check("idle_no_write", bus.wr_en, 0);

        // Async reset in the middle of a capture.
        arm_capture(4, 1'b0, 8'h80);
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst_wr_en", bus.wr_en, 0);
        check("async_rst_busy", bus.busy, 0);
        model_reset();
        bus.adc_valid = 0; bus.arm = 0; bus.abort = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized captures.
        for (int r = 0; r < 6; r++) begin
            int pd;
            case (r % 4)
                0: pd = 0;
                1: pd = 1023;
                default: pd = $urandom_range(1, 1022);
            endcase
            arm_capture(pd, 1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)));
            run_capture(3, 8000, fin);
            check("rand_capture_end", fin, 1);
            if (!fin) cycle(1'b0, 8'h00, 1'b0, 1'b1);
            repeat (3) cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        // Constant input never crosses the level.
        arm_capture(8, 1'b0, 8'h80);
`ifdef DSO_AUTO_TRIG_EN
        run_capture(2, 3000, fin);
        check("auto_finished", fin, 1);
        check("auto_trig_addr", bus.trig_addr, 107);
        check("auto_start_addr", bus.start_addr, 99);
        check("auto_forced", bus.forced, 1);
        check("auto_done", bus.done, 1);
`else
        run_capture(2, 5008, fin);
        check("no_auto_still_waiting", fin, 0);
        check("no_auto_done", bus.done, 0);
        check("no_auto_busy", bus.busy, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
`endif
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
